// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system ID boot checker.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned SYSID_TMR_W = 16;

endpackage

// File: rtl/sysid_ctrl_stall_timer.sv
// Clearable saturating cycle counter; terminal_c flags the cycle whose edge
// brings the count to LIMIT.
module sysid_ctrl_stall_timer
  import sysid_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam logic [SYSID_TMR_W-1:0] LIMIT_W = SYSID_TMR_W'(LIMIT);
  localparam logic [SYSID_TMR_W-1:0] LAST_W  = SYSID_TMR_W'(LIMIT - 1);

  logic [SYSID_TMR_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_W)) begin
      count <= count + SYSID_TMR_W'(1);
    end
  end

  assign terminal_c = enable && (count == LAST_W);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sequencer that reads and verifies the system ID and timestamp words.
// Optional stall timeout enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1549930689,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count,
  output logic        timeout_err,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int unsigned LAT_LIMIT = (READ_LATENCY == 0) ? 1 : READ_LATENCY;
  localparam logic        LAT_ZERO  = (READ_LATENCY == 0);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state, state_nxt;
  logic        start_q;
  logic        in_rd, in_wait, accept, lat_done, tmo;
  logic        id_match, ts_match, capture_id, capture_ts, start_acc;
  logic        busy_nxt, done_nxt, id_ok_nxt, ts_ok_nxt, timeout_err_nxt;
  logic        avm_address_nxt, avm_read_nxt;
  logic [31:0] id_value_nxt, ts_value_nxt;
  logic [3:0]  retry_count_nxt;

  assign in_rd      = (state == RD_ID) || (state == RD_TS);
  assign in_wait    = (state == WAIT_ID) || (state == WAIT_TS);
  assign accept     = in_rd && !avm_waitrequest;
  assign id_match   = (id_value == EXPECTED_ID);
  assign ts_match   = (ts_value == EXPECTED_TS);
  assign start_acc  = ((state == IDLE) || (state == DONE)) && start_q;
  assign capture_id = ((state == RD_ID) && accept && LAT_ZERO) || ((state == WAIT_ID) && lat_done);
  assign capture_ts = ((state == RD_TS) && accept && LAT_ZERO) || ((state == WAIT_TS) && lat_done);

  sysid_ctrl_stall_timer #(.LIMIT(LAT_LIMIT)) u_lat_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (!in_wait),
    .enable     (in_wait),
    .terminal_c (lat_done)
  );

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic tmo_hit;

  // Counts consecutive stalled cycles of the current read request.
  sysid_ctrl_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_tmo_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (!in_rd || !avm_waitrequest),
    .enable     (in_rd && avm_waitrequest),
    .terminal_c (tmo_hit)
  );

  assign tmo = tmo_hit;
`else
  assign tmo = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_count <= '0;
      timeout_err <= 1'b0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_q     <= start && ((state == IDLE) || (state == DONE));
      busy        <= busy_nxt;
      done        <= done_nxt;
      id_ok       <= id_ok_nxt;
      ts_ok       <= ts_ok_nxt;
      id_value    <= id_value_nxt;
      ts_value    <= ts_value_nxt;
      retry_count <= retry_count_nxt;
      timeout_err <= timeout_err_nxt;
      avm_address <= avm_address_nxt;
      avm_read    <= avm_read_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_q) state_nxt = RD_ID;
      RD_ID: begin
        if (tmo)         state_nxt = DONE;
        else if (accept) state_nxt = LAT_ZERO ? RD_TS : WAIT_ID;
      end
      WAIT_ID: if (lat_done) state_nxt = RD_TS;
      RD_TS: begin
        if (tmo)         state_nxt = DONE;
        else if (accept) state_nxt = LAT_ZERO ? CHECK : WAIT_TS;
      end
      WAIT_TS: if (lat_done) state_nxt = CHECK;
      CHECK: begin
        if (id_match && ts_match)       state_nxt = DONE;
        else if (retry_count < RETRY_MAX) state_nxt = RD_ID;
        else                            state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    busy_nxt        = !((state_nxt == IDLE) || (state_nxt == DONE));
    done_nxt        = (state_nxt == DONE);
    avm_read_nxt    = (state_nxt == RD_ID) || (state_nxt == RD_TS);
    avm_address_nxt = avm_address;
    id_ok_nxt       = id_ok;
    ts_ok_nxt       = ts_ok;
    id_value_nxt    = id_value;
    ts_value_nxt    = ts_value;
    retry_count_nxt = retry_count;
    timeout_err_nxt = timeout_err;

    if (state_nxt == RD_ID)      avm_address_nxt = SYSID_ADDR_ID;
    else if (state_nxt == RD_TS) avm_address_nxt = SYSID_ADDR_TS;

    if (start_acc) begin
      id_ok_nxt       = 1'b0;
      ts_ok_nxt       = 1'b0;
      retry_count_nxt = '0;
      timeout_err_nxt = 1'b0;
    end

    if (capture_id) id_value_nxt = avm_readdata;
    if (capture_ts) ts_value_nxt = avm_readdata;

    if (state == CHECK) begin
      id_ok_nxt = id_match;
      ts_ok_nxt = ts_match;
      if (state_nxt == RD_ID) retry_count_nxt = retry_count + 4'd1;
    end

    if (tmo) begin
      timeout_err_nxt = 1'b1;
      id_ok_nxt       = 1'b0;
      ts_ok_nxt       = 1'b0;
    end
  end

endmodule
